// File: rtl/ap_ctrl_driver_pkg.sv
// ap_ctrl_driver shared types and constants.
// States, default widths and the LFSR constants used by the optional stall generator.
package ap_ctrl_driver_pkg;

    localparam int MAX_INFLIGHT_DEF = 4;
    localparam int CNT_W_DEF        = 32;
    localparam int TXN_W_DEF        = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_e;

    function automatic logic lfsr_fb(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/ap_ctrl_driver_if.sv
// ap_ctrl_chain block-level handshake between the driver and one kernel.
// master = driver side, slave = kernel side.
interface ap_ctrl_driver_if;

    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (
        output ap_start,
        output ap_continue,
        input  ap_ready,
        input  ap_done
    );

    modport slave (
        input  ap_start,
        input  ap_continue,
        output ap_ready,
        output ap_done
    );

endinterface

// File: rtl/ap_ctrl_ts_fifo.sv
// Start-timestamp FIFO for issued-but-not-retired transactions.
// Push and pop may share a cycle; pop always sees the old head (no bypass).
module ap_ctrl_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [NW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == NW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rp];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + NW'(1);
                2'b01:   r_cnt <= r_cnt - NW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_chain initiator: issues N transactions, bounds overlap, measures latency/II.
// Define AP_CTRL_DRIVER_BACKPRESSURE_EN to gate ap_continue with a 16-bit LFSR while busy.
module ap_ctrl_driver
    import ap_ctrl_driver_pkg::*;
#(
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int TXN_W        = TXN_W_DEF
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                cfg_start,
    input  logic [TXN_W-1:0]    cfg_num_txn,
    output logic                busy,
    output logic                done,
    ap_ctrl_driver_if.master    kif,
    output logic [TXN_W-1:0]    issued_cnt,
    output logic [TXN_W-1:0]    completed_cnt,
    output logic [CNT_W-1:0]    lat_last,
    output logic [CNT_W-1:0]    lat_max,
    output logic [CNT_W-1:0]    ii_last,
    output logic                err_orphan
);

    state_e r_state;
    state_e w_next;

    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_ts;
    logic [CNT_W-1:0] r_prev_acc;
    logic [CNT_W-1:0] r_lat_last;
    logic [CNT_W-1:0] r_lat_max;
    logic [CNT_W-1:0] r_ii_last;
    logic [TXN_W-1:0] r_target;
    logic [TXN_W-1:0] r_issued;
    logic [TXN_W-1:0] r_completed;
    logic             r_ts_held;
    logic             r_first;
    logic             r_done;
    logic             r_err;

    logic             w_busy;
    logic             w_start;
    logic             w_accept;
    logic             w_ret;
    logic             w_pop;
    logic             w_orphan;
    logic             w_cfg_go;
    logic             w_cont;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_head;
    logic [CNT_W-1:0] w_ts;
    logic [CNT_W-1:0] w_lat;

    assign w_busy   = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    // Pushes happen only on acceptance, so a raised ap_start cannot be
    // withdrawn by the FIFO filling up.
    assign w_start  = (r_state == S_ISSUE) && (r_issued < r_target) && !w_full;
    assign w_accept = w_start && kif.ap_ready;
    assign w_ret    = w_busy && kif.ap_done && w_cont;
    assign w_pop    = w_ret && !w_empty;
    assign w_orphan = w_ret && w_empty;
    assign w_cfg_go = (r_state == S_IDLE) && cfg_start;
    assign w_ts     = r_ts_held ? r_ts : r_cyc;
    assign w_lat    = r_cyc - w_head;

`ifdef AP_CTRL_DRIVER_BACKPRESSURE_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], lfsr_fb(r_lfsr)};
        end
    end

    assign w_cont = w_busy ? (r_lfsr[1:0] != 2'b00) : 1'b1;
`else
    assign w_cont = 1'b1;
`endif

    ap_ctrl_ts_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .W     (CNT_W)
    ) u_ts_fifo (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_push  (w_accept),
        .i_din   (w_ts),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_next = (cfg_num_txn != '0) ? S_ISSUE : S_FINISH;
                end
            end
            S_ISSUE: begin
                if (w_accept && (r_issued + TXN_W'(1) == r_target)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_completed == r_target) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_cyc       <= '0;
            r_ts        <= '0;
            r_prev_acc  <= '0;
            r_lat_last  <= '0;
            r_lat_max   <= '0;
            r_ii_last   <= '0;
            r_target    <= '0;
            r_issued    <= '0;
            r_completed <= '0;
            r_ts_held   <= 1'b0;
            r_first     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cyc <= r_cyc + CNT_W'(1);
            if (w_cfg_go) begin
                r_done <= 1'b0;
                if (cfg_num_txn != '0) begin
                    r_target    <= cfg_num_txn;
                    r_issued    <= '0;
                    r_completed <= '0;
                    r_lat_max   <= '0;
                    r_err       <= 1'b0;
                    r_first     <= 1'b1;
                    r_ts_held   <= 1'b0;
                end
            end
            if (r_state == S_FINISH) begin
                r_done <= 1'b1;
            end
            // Timestamp is taken on the first cycle ap_start is high.
            if (w_start && !w_accept && !r_ts_held) begin
                r_ts_held <= 1'b1;
                r_ts      <= r_cyc;
            end
            if (w_accept) begin
                r_ts_held  <= 1'b0;
                r_issued   <= r_issued + TXN_W'(1);
                r_ii_last  <= r_first ? '0 : (r_cyc - r_prev_acc);
                r_prev_acc <= r_cyc;
                r_first    <= 1'b0;
            end
            if (w_pop) begin
                r_lat_last  <= w_lat;
                r_completed <= r_completed + TXN_W'(1);
                if (w_lat > r_lat_max) begin
                    r_lat_max <= w_lat;
                end
            end
            if (w_orphan) begin
                r_err <= 1'b1;
            end
        end
    end

    assign kif.ap_start    = w_start;
    assign kif.ap_continue = w_cont;
    assign busy            = w_busy;
    assign done            = r_done;
    assign issued_cnt      = r_issued;
    assign completed_cnt   = r_completed;
    assign lat_last        = r_lat_last;
    assign lat_max         = r_lat_max;
    assign ii_last         = r_ii_last;
    assign err_orphan      = r_err;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Bench for ap_ctrl_driver: behavioural kernel plus a transaction-level reference model.
// Directed scenarios followed by randomized runs; every cycle is compared against the model.
module tb_ap_ctrl_driver;

    localparam int MI = 4;
    localparam int CW = 32;
    localparam int TW = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [TW-1:0] cfg_num_txn = '0;
    logic          busy;
    logic          done;
    logic [TW-1:0] issued_cnt;
    logic [TW-1:0] completed_cnt;
    logic [CW-1:0] lat_last;
    logic [CW-1:0] lat_max;
    logic [CW-1:0] ii_last;
    logic          err_orphan;

    ap_ctrl_driver_if kif();

    ap_ctrl_driver #(
        .MAX_INFLIGHT (MI),
        .CNT_W        (CW),
        .TXN_W        (TW)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .cfg_start     (cfg_start),
        .cfg_num_txn   (cfg_num_txn),
        .busy          (busy),
        .done          (done),
        .kif           (kif),
        .issued_cnt    (issued_cnt),
        .completed_cnt (completed_cnt),
        .lat_last      (lat_last),
        .lat_max       (lat_max),
        .ii_last       (ii_last),
        .err_orphan    (err_orphan)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Kernel knobs and state
    int     k_ready_pct = 100;
    int     k_lat_min = 5;
    int     k_lat_max = 5;
    bit     k_inject = 1'b0;
    longint kq[$];
    longint tcyc = 0;
    int     max_fl = 0;
    int     starts_seen = 0;
    bit     s_start;
    bit     s_cont;

    // Reference model: transaction counts, timestamp queue, run phase
    bit     m_busy, m_fin, m_done, m_err, m_pend, m_first;
    int     m_tgt, m_iss, m_cmp;
    longint m_lat_last, m_lat_max, m_ii, m_prev, m_pts;
    longint m_q[$];
    int     iss0, cmp0;
    bit     st, ret, acc;
    longint lat;

    task automatic model_reset();
        m_busy = 0; m_fin = 0; m_done = 0; m_err = 0; m_pend = 0; m_first = 0;
        m_tgt = 0; m_iss = 0; m_cmp = 0;
        m_lat_last = 0; m_lat_max = 0; m_ii = 0; m_prev = 0; m_pts = 0;
        m_q.delete();
    endtask

    initial model_reset();

    always @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            model_reset();
            kq.delete();
        end else begin
            if (kq.size() > 0 && kq[0] <= tcyc && s_cont) begin
                void'(kq.pop_front());
            end
            if (s_start && kif.ap_ready) begin
                kq.push_back(tcyc + longint'($urandom_range(k_lat_max, k_lat_min)));
                if (kq.size() > max_fl) max_fl = kq.size();
            end

            iss0 = m_iss;
            cmp0 = m_cmp;
            st = m_busy && (m_iss < m_tgt) && (m_q.size() < MI);
            if (st && !m_pend) begin
                m_pend = 1;
                m_pts = tcyc;
            end
            ret = m_busy && kif.ap_done && s_cont;
            acc = st && kif.ap_ready;
            if (ret) begin
                if (m_q.size() == 0) begin
                    m_err = 1;
                end else begin
                    lat = tcyc - m_q.pop_front();
                    m_lat_last = lat;
                    if (lat > m_lat_max) m_lat_max = lat;
                    m_cmp++;
                end
            end
            if (acc) begin
                m_q.push_back(m_pts);
                m_pend = 0;
                m_ii = m_first ? 0 : tcyc - m_prev;
                m_prev = tcyc;
                m_first = 0;
                m_iss++;
            end
            if (m_fin) begin
                m_fin = 0;
                m_done = 1;
            end else if (m_busy) begin
                if (iss0 == m_tgt && cmp0 == m_tgt) begin
                    m_busy = 0;
                    m_fin = 1;
                end
            end else if (cfg_start) begin
                m_done = 0;
                if (cfg_num_txn == 0) begin
                    m_fin = 1;
                end else begin
                    m_busy = 1;
                    m_tgt = cfg_num_txn;
                    m_iss = 0;
                    m_cmp = 0;
                    m_lat_max = 0;
                    m_err = 0;
                    m_first = 1;
                    m_pend = 0;
                end
            end
        end
        tcyc++;
    end

    // Compare process and kernel drive
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("ap_start", kif.ap_start,
                m_busy && (m_iss < m_tgt) && (m_q.size() < MI));
`ifndef AP_CTRL_DRIVER_BACKPRESSURE_EN
            chk("ap_continue", kif.ap_continue, 1'b1);
`endif
            chk("issued_cnt", issued_cnt, m_iss);
            chk("completed_cnt", completed_cnt, m_cmp);
            chk("lat_last", lat_last, m_lat_last);
            chk("lat_max", lat_max, m_lat_max);
            chk("ii_last", ii_last, m_ii);
            chk("err_orphan", err_orphan, m_err);
        end
        s_start = kif.ap_start;
        s_cont = kif.ap_continue;
        if (s_start) starts_seen++;
        kif.ap_ready = ($urandom_range(99, 0) < k_ready_pct);
        kif.ap_done = k_inject || (kq.size() > 0 && kq[0] <= tcyc);
    end

    task automatic start_run(input int n);
        @(negedge ap_clk);
        cfg_start = 1'b1;
        cfg_num_txn = TW'(n);
        @(negedge ap_clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        for (int i = 0; i < budget && !m_done; i++) @(negedge ap_clk);
        n_checks++;
        if (!m_done) begin
            n_errors++;
            $display("FAIL %s_timeout: run not finished after %0d cycles", nm, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int s0;

    initial begin
        repeat (3) @(negedge ap_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ap_start", kif.ap_start, 0);
        chk("rst_issued", issued_cnt, 0);
        chk("rst_lat_max", lat_max, 0);
        chk("rst_err", err_orphan, 0);
        ap_rst_n = 1'b1;

        // Immediate ready, latency 5, three transactions
        k_ready_pct = 100; k_lat_min = 5; k_lat_max = 5;
        start_run(3);
        wait_done("t1", 200);
        chk("t1_issued", issued_cnt, 3);
        chk("t1_completed", completed_cnt, 3);
        chk("t1_lat_last", lat_last, 5);
        chk("t1_lat_max", lat_max, 5);
        chk("t1_ii", ii_last, 1);
        chk("t1_done", done, 1);
        chk("t1_err", err_orphan, 0);

        // Latency 20, eight transactions: in-flight bound; cfg_start while busy ignored
        k_lat_min = 20; k_lat_max = 20; max_fl = 0;
        start_run(8);
        repeat (3) @(negedge ap_clk);
        cfg_start = 1'b1; cfg_num_txn = 1;
        @(negedge ap_clk);
        cfg_start = 1'b0;
        wait_done("t2", 400);
        chk("t2_max_inflight", max_fl, 4);
        chk("t2_completed", completed_cnt, 8);
        chk("t2_lat_max", lat_max, 20);
        chk("t2_ii", ii_last, 1);

        // Zero-length run
        s0 = starts_seen;
        @(negedge ap_clk);
        cfg_start = 1'b1; cfg_num_txn = 0;
        @(negedge ap_clk);
        cfg_start = 1'b0;
        chk("t3_done_c1", done, 0);
        chk("t3_busy_c1", busy, 0);
        @(negedge ap_clk);
        chk("t3_done_c2", done, 1);
        chk("t3_no_start", starts_seen - s0, 0);

        // Orphan ap_done while nothing is outstanding
        k_ready_pct = 0; k_lat_min = 5; k_lat_max = 5;
        start_run(2);
        @(posedge ap_clk);
        k_inject = 1'b1;
        @(posedge ap_clk);
        k_inject = 1'b0;
        repeat (2) @(negedge ap_clk);
        chk("t4_err", err_orphan, 1);
        chk("t4_completed", completed_cnt, 0);
        k_ready_pct = 100;
        wait_done("t4", 200);
        chk("t4_completed_end", completed_cnt, 2);
        chk("t4_err_end", err_orphan, 1);

        // Cycle counter wrap, latency 10
        @(negedge ap_clk);
        force dut.r_cyc = 32'hFFFF_FFFD;
        @(negedge ap_clk);
        release dut.r_cyc;
        k_lat_min = 10; k_lat_max = 10;
        start_run(1);
        chk("t5_err_cleared", err_orphan, 0);
        wait_done("t5", 200);
        chk("t5_lat_wrap", lat_last, 10);
        chk("t5_completed", completed_cnt, 1);

        // Reset in DRAIN with two outstanding, then a clean run of two
        k_lat_min = 15; k_lat_max = 15;
        start_run(2);
        for (int i = 0; i < 50 && !(m_busy && m_iss == 2); i++) @(negedge ap_clk);
        chk("t6_in_drain", m_q.size(), 2);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("t6_ap_start", kif.ap_start, 0);
        chk("t6_busy", busy, 0);
        chk("t6_issued", issued_cnt, 0);
        chk("t6_completed", completed_cnt, 0);
        chk("t6_lat_last", lat_last, 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        start_run(2);
        wait_done("t6", 200);
        chk("t6_completed_end", completed_cnt, 2);
        chk("t6_lat_last_end", lat_last, 15);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            k_ready_pct = $urandom_range(100, 30);
            k_lat_min = 1;
            k_lat_max = $urandom_range(12, 1);
            start_run($urandom_range(12, 1));
            wait_done("rand", 3000);
        end

        repeat (3) @(negedge ap_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
